// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared LCD geometry constants, scheduler state encoding and page helper
//
// Contents:
//   LCD_WIDTH, LCD_PAGES, ADDR_W, FRAME_BYTES  - 128x64 panel geometry, one byte per column per page
//   IDLE, HOLD, SEND, DONE                     - frame scheduler state encoding
//   is_bar_page()                              - true for the two pages occupied by the progress bar
package lcd_pkg;

  localparam int LCD_WIDTH   = 128;
  localparam int LCD_PAGES   = 8;
  localparam int ADDR_W      = 10;
  localparam int FRAME_BYTES = LCD_WIDTH * LCD_PAGES;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // The bar spans bar_page (top half) and bar_page+1 (bottom half).
  function automatic logic is_bar_page(input logic [2:0] page, input int bar_page);
    return (int'(page) == bar_page) || (int'(page) == bar_page + 1);
  endfunction

endpackage

// File: rtl/lcd_frame_scheduler_if.sv
// rtl/lcd_frame_scheduler_if.sv - byte stream from the frame scheduler to the SPI byte sender
//
// Signals:
//   tdata  [7:0]  display byte
//   tvalid        tdata is valid
//   tready        sender accepts tdata this cycle
// Modports: master (scheduler side), slave (SPI sender side)
interface lcd_frame_scheduler_if;

  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/lcd_frame_scheduler.sv
// rtl/lcd_frame_scheduler.sv - walks one 1024-byte LCD frame, picks text/bar bytes, streams them out
//
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_start               request one frame refresh (only honoured in IDLE)
//   i_value / o_value     live progress value / value latched at frame start
//   o_pixelAddress        {page[2:0], column[6:0]} shared by both row generators
//   i_textData, i_barData registered bytes from the text and progressbar generators
//   byte_out              byte stream to the SPI sender (master side)
//   o_busy                frame in progress
//   o_frameDone           one-cycle pulse after the last byte is accepted
module lcd_frame_scheduler
  import lcd_pkg::*;
#(
  parameter int BAR_PAGE      = 2,
  parameter int PIXEL_LATENCY = 2,
  parameter int AUTO_REFRESH  = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [7:0]             i_value,
  output logic [7:0]             o_value,
  output logic [ADDR_W-1:0]      o_pixelAddress,
  input  logic [7:0]             i_textData,
  input  logic [7:0]             i_barData,
  lcd_frame_scheduler_if.master  byte_out,
  output logic                   o_busy,
  output logic                   o_frameDone
);

  localparam int                CNT_W     = (PIXEL_LATENCY > 1) ? $clog2(PIXEL_LATENCY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PIXEL_LATENCY - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] hold_cnt;
  logic [7:0]       byte_q;
  logic             byte_valid_q;
  logic             frame_start;

  assign byte_out.tdata  = byte_q;
  assign byte_out.tvalid = byte_valid_q;

  // o_frameDone is high only in the IDLE cycle right after DONE, so it
  // doubles as the "DONE just left" trigger for auto refresh.
  assign frame_start = i_start || ((AUTO_REFRESH != 0) && o_frameDone);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      hold_cnt       <= '0;
      byte_q         <= '0;
      byte_valid_q   <= 1'b0;
      o_value        <= '0;
      o_pixelAddress <= '0;
      o_busy         <= 1'b0;
      o_frameDone    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_frameDone <= 1'b0;
          if (frame_start) begin
            o_value        <= i_value;
            o_pixelAddress <= '0;
            hold_cnt       <= '0;
            o_busy         <= 1'b1;
            state          <= HOLD;
          end
        end
        HOLD: begin
          // Address has been stable for PIXEL_LATENCY cycles once the
          // counter hits its last value, so the generator byte is current.
          if (hold_cnt == CNT_LAST) begin
            byte_q       <= is_bar_page(o_pixelAddress[ADDR_W-1 -: 3], BAR_PAGE) ? i_barData
                                                                                 : i_textData;
            byte_valid_q <= 1'b1;
            state        <= SEND;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        SEND: begin
          if (byte_out.tready) begin
            byte_valid_q <= 1'b0;
            if (o_pixelAddress == LAST_ADDR) begin
              state <= DONE;
            end else begin
              // Column 127 rolls into the next page via the plain increment.
              o_pixelAddress <= o_pixelAddress + 1'b1;
              hold_cnt       <= '0;
              state          <= HOLD;
            end
          end
        end
        DONE: begin
          o_frameDone <= 1'b1;
          o_busy      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// tb/tb_lcd_frame_scheduler.sv - randomized self-checking bench for lcd_frame_scheduler
module tb_lcd_frame_scheduler;

  localparam int BAR = 2;
  localparam int FRAME_CYCLES = 1024 * (2 + 1) + 2;

  logic       clk;
  logic       rst_n;
  logic       start0, start1;
  logic [7:0] value0, value1, out_value0, out_value1;
  logic [9:0] addr0, addr1;
  logic [7:0] text0, bar0, text1, bar1;
  logic       busy0, busy1, done0, done1;

  lcd_frame_scheduler_if bus0 ();
  lcd_frame_scheduler_if bus1 ();

  lcd_frame_scheduler #(.BAR_PAGE(BAR), .PIXEL_LATENCY(2), .AUTO_REFRESH(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .i_value(value0), .o_value(out_value0),
    .o_pixelAddress(addr0), .i_textData(text0), .i_barData(bar0), .byte_out(bus0),
    .o_busy(busy0), .o_frameDone(done0)
  );

  lcd_frame_scheduler #(.BAR_PAGE(BAR), .PIXEL_LATENCY(2), .AUTO_REFRESH(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_value(value1), .o_value(out_value1),
    .o_pixelAddress(addr1), .i_textData(text1), .i_barData(bar1), .byte_out(bus1),
    .o_busy(busy1), .o_frameDone(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generator models: content derived from the address, one register of latency.
  logic [7:0] txt_base, bar_base;
  bit         mix;

  function automatic logic [7:0] txt_fn(input logic [9:0] a);
    return mix ? (txt_base ^ a[7:0]) : txt_base;
  endfunction

  function automatic logic [7:0] bar_fn(input logic [9:0] a);
    return mix ? (bar_base ^ a[9:2]) : bar_base;
  endfunction

  always_ff @(posedge clk) begin
    text0 <= txt_fn(addr0);
    bar0  <= bar_fn(addr0);
    text1 <= txt_fn(addr1);
    bar1  <= bar_fn(addr1);
  end

  // Reference: byte k of the frame is column k%128 of page k/128.
  function automatic logic [7:0] exp_byte(input int k);
    int page;
    page = k / 128;
    if (page == BAR || page == BAR + 1) return bar_fn(10'(k));
    return txt_fn(10'(k));
  endfunction

  int checks, failures;
  int done_cycle, done_pulses, value_bad, stall_bad, byte_bad, nacc, waits, busy_tail;
  int first_bad_idx;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame on dut0 and scoreboards every accepted byte.
  task automatic run0(input logic [7:0] val, input int stall_at, input int stall_len,
                      input int chg_at, input logic [7:0] chg_val, input int stop_at,
                      input int busy_start_at, input bit rand_ready);
    int         stall_rem;
    bit         stalled, chg_done, bs_done;
    logic [7:0] snap;
    stall_rem = 0; stalled = 0; chg_done = 0; bs_done = 0; snap = 8'h00;
    done_cycle = -1; done_pulses = 0; value_bad = 0; stall_bad = 0; byte_bad = 0;
    nacc = 0; waits = 0; busy_tail = 0; first_bad_idx = -1;
    value0 = val; start0 = 1'b1; bus0.tready = 1'b1;
    for (int n = 1; n <= 12000; n++) begin
      if (bus0.tvalid === 1'b1 && bus0.tready === 1'b1) begin
        if (int'(addr0) != nacc || bus0.tdata !== exp_byte(nacc)) begin
          byte_bad++;
          if (first_bad_idx < 0) first_bad_idx = nacc;
        end
        nacc++;
      end
      if (bus0.tvalid === 1'b1 && bus0.tready === 1'b0) waits++;
      tick();
      start0 = 1'b0;
      if (done0) begin
        done_pulses++;
        if (done_cycle < 0) done_cycle = n;
      end
      if (busy0 && out_value0 !== val) value_bad++;
      if (done_cycle > 0 && n > done_cycle && busy0 !== 1'b0) busy_tail++;
      if (done_cycle > 0 && n >= done_cycle + 4) break;
      if (stop_at >= 0 && busy0 && int'(addr0) == stop_at) break;
      if (!chg_done && chg_at >= 0 && int'(addr0) == chg_at) begin
        value0 = chg_val; chg_done = 1;
      end
      if (!bs_done && busy_start_at >= 0 && int'(addr0) == busy_start_at) begin
        start0 = 1'b1; bs_done = 1;
      end
      if (stall_rem > 0) begin
        if (!(bus0.tvalid === 1'b1 && bus0.tdata === snap && int'(addr0) == stall_at)) stall_bad++;
        stall_rem--;
        if (stall_rem == 0) bus0.tready = 1'b1;
      end else if (!stalled && stall_at >= 0 && bus0.tvalid === 1'b1 && int'(addr0) == stall_at) begin
        stalled = 1; snap = bus0.tdata; bus0.tready = 1'b0; stall_rem = stall_len;
      end else if (rand_ready) begin
        bus0.tready = 1'($urandom_range(0, 1));
      end
    end
    bus0.tready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; value0 = 8'hFF; value1 = 8'hFF;
    bus0.tready = 1'b1; bus1.tready = 1'b1;
    repeat (3) tick();
    checks++; if (out_value0 !== 8'h00) begin failures++; $display("FAIL reset_value got=%0h want=0", out_value0); end
    checks++; if (addr0 !== 10'd0) begin failures++; $display("FAIL reset_addr got=%0d want=0", addr0); end
    checks++; if (bus0.tdata !== 8'h00) begin failures++; $display("FAIL reset_byte got=%0h want=0", bus0.tdata); end
    checks++; if (bus0.tvalid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", bus0.tvalid); end
    checks++; if (busy0 !== 1'b0 || busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b%b want=00", busy0, busy1); end
    checks++; if (done0 !== 1'b0 || done1 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b%b want=00", done0, done1); end
    rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (busy0 !== 1'b0 || busy1 !== 1'b0) begin failures++; $display("FAIL idle_no_start busy got=%b%b want=00", busy0, busy1); end
  endtask

  task automatic test_full_frame();
    mix = 1; txt_base = 8'($urandom); bar_base = 8'($urandom);
    run0(8'd100, -1, 0, -1, 8'h00, -1, -1, 0);
    checks++; if (nacc != 1024 || byte_bad != 0) begin failures++; $display("FAIL full_bytes got=%0d bad=%0d first=%0d want=1024 bad=0", nacc, byte_bad, first_bad_idx); end
    checks++; if (value_bad != 0) begin failures++; $display("FAIL full_value got=%0d bad cycles want=0", value_bad); end
    checks++; if (done_cycle != FRAME_CYCLES) begin failures++; $display("FAIL full_latency got=%0d want=%0d", done_cycle, FRAME_CYCLES); end
    checks++; if (done_pulses != 1) begin failures++; $display("FAIL full_done_pulses got=%0d want=1", done_pulses); end
    checks++; if (busy_tail != 0) begin failures++; $display("FAIL full_busy_after got=%0d want=0", busy_tail); end
  endtask

  task automatic test_gen_select();
    mix = 0; txt_base = 8'hAA; bar_base = 8'h55;
    run0(8'($urandom), -1, 0, -1, 8'h00, -1, -1, 0);
    checks++; if (nacc != 1024 || byte_bad != 0) begin failures++; $display("FAIL gen_select got=%0d bad=%0d first=%0d want=1024 bad=0", nacc, byte_bad, first_bad_idx); end
  endtask

  task automatic test_backpressure();
    int stall_at;
    mix = 1; txt_base = 8'($urandom); bar_base = 8'($urandom);
    stall_at = 130;
    run0(8'd40, stall_at, 5, 500, 8'd200, -1, -1, 0);
    checks++; if (stall_bad != 0) begin failures++; $display("FAIL stall_stable got=%0d unstable cycles want=0", stall_bad); end
    checks++; if (nacc != 1024 || byte_bad != 0) begin failures++; $display("FAIL stall_bytes got=%0d bad=%0d first=%0d want=1024 bad=0", nacc, byte_bad, first_bad_idx); end
    checks++; if (done_cycle != FRAME_CYCLES + 5) begin failures++; $display("FAIL stall_latency got=%0d want=%0d", done_cycle, FRAME_CYCLES + 5); end
    checks++; if (value_bad != 0) begin failures++; $display("FAIL value_midframe got=%0d bad cycles want=0", value_bad); end
    checks++; if (out_value0 !== 8'd40) begin failures++; $display("FAIL value_after_frame got=%0d want=40", out_value0); end
  endtask

  task automatic test_relatch_and_busy_start();
    mix = 1; txt_base = 8'($urandom); bar_base = 8'($urandom);
    run0(8'd200, -1, 0, -1, 8'h00, -1, 300, 0);
    checks++; if (value_bad != 0) begin failures++; $display("FAIL relatch_value got=%0d bad cycles want=0", value_bad); end
    checks++; if (done_cycle != FRAME_CYCLES) begin failures++; $display("FAIL busy_start_latency got=%0d want=%0d", done_cycle, FRAME_CYCLES); end
    checks++; if (busy_tail != 0) begin failures++; $display("FAIL busy_start_queued got=%0d busy cycles want=0", busy_tail); end
  endtask

  task automatic test_random_ready();
    logic [7:0] v;
    mix = 1; txt_base = 8'($urandom); bar_base = 8'($urandom); v = 8'($urandom);
    run0(v, -1, 0, -1, 8'h00, -1, -1, 1);
    checks++; if (nacc != 1024 || byte_bad != 0) begin failures++; $display("FAIL rand_ready_bytes got=%0d bad=%0d first=%0d want=1024 bad=0", nacc, byte_bad, first_bad_idx); end
    checks++; if (done_cycle != FRAME_CYCLES + waits) begin failures++; $display("FAIL rand_ready_latency got=%0d want=%0d", done_cycle, FRAME_CYCLES + waits); end
    checks++; if (done_pulses != 1 || value_bad != 0) begin failures++; $display("FAIL rand_ready_misc pulses=%0d valuebad=%0d want=1,0", done_pulses, value_bad); end
  endtask

  task automatic test_reset_midframe();
    mix = 1; txt_base = 8'($urandom); bar_base = 8'($urandom);
    run0(8'($urandom_range(1, 255)), -1, 0, -1, 8'h00, 700, -1, 0);
    checks++; if (addr0 !== 10'd700) begin failures++; $display("FAIL midreset_reach got=%0d want=700", addr0); end
    rst_n = 1'b0;
    tick();
    checks++; if ({out_value0, addr0, bus0.tdata, bus0.tvalid, busy0, done0} !== 30'd0) begin
      failures++;
      $display("FAIL midreset_outputs got=%0h/%0d/%0h/%b/%b/%b want=all 0", out_value0, addr0, bus0.tdata, bus0.tvalid, busy0, done0);
    end
    rst_n = 1'b1;
    tick();
    checks++; if (done0 !== 1'b0 || done_pulses != 0) begin failures++; $display("FAIL midreset_done got=%b/%0d want=0", done0, done_pulses); end
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    checks++; if (busy0 !== 1'b1 || addr0 !== 10'd0) begin failures++; $display("FAIL midreset_restart busy=%b addr=%0d want=1,0", busy0, addr0); end
    tick(); tick();
    checks++; if (bus0.tvalid !== 1'b1 || bus0.tdata !== exp_byte(0)) begin
      failures++; $display("FAIL midreset_first_byte got=%b/%0h want=1/%0h", bus0.tvalid, bus0.tdata, exp_byte(0));
    end
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
  endtask

  task automatic test_auto_refresh();
    logic [7:0] v1, v2;
    int         dc, vbad;
    mix = 1; txt_base = 8'($urandom); bar_base = 8'($urandom);
    v1 = 8'($urandom); v2 = ~v1;
    dc = -1; vbad = 0;
    value1 = v1; start1 = 1'b1; bus1.tready = 1'b1;
    for (int n = 1; n <= 4000; n++) begin
      tick();
      start1 = 1'b0;
      if (busy1 && out_value1 !== v1) vbad++;
      if (int'(addr1) == 600) value1 = v2;
      if (done1) begin dc = n; break; end
    end
    checks++; if (dc != FRAME_CYCLES) begin failures++; $display("FAIL auto_latency got=%0d want=%0d", dc, FRAME_CYCLES); end
    checks++; if (vbad != 0) begin failures++; $display("FAIL auto_value_hold got=%0d bad cycles want=0", vbad); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL auto_busy_at_done got=%b want=0", busy1); end
    tick();
    checks++; if (busy1 !== 1'b1 || addr1 !== 10'd0 || out_value1 !== v2) begin
      failures++; $display("FAIL auto_restart busy=%b addr=%0d value=%0h want=1,0,%0h", busy1, addr1, out_value1, v2);
    end
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
  endtask

  initial begin
    checks = 0; failures = 0;
    mix = 0; txt_base = 8'h00; bar_base = 8'h00;
    test_reset();
    test_full_frame();
    test_gen_select();
    test_backpressure();
    test_relatch_and_busy_start();
    test_random_ready();
    test_reset_midframe();
    test_auto_refresh();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_frame_scheduler.md
Name: lcd_frame_scheduler

Overview:
- Sequences a full 128x64 monochrome LCD frame: 1024 bytes, 8 pages of 128 columns, one byte per column per page.
- Drives the pixel address shared by the text-row generator and the progressbar-row generator, and waits out their registered latency.
- Selects which generator's byte goes out, and streams bytes to the SPI byte sender over a valid/ready handshake.
- Latches the progress value once per frame so the bar never tears mid-refresh.

Parameters:
- BAR_PAGE, 2, first of the two pages holding the progress bar. Must be even and in 0..6. Page BAR_PAGE is the bar's top half, BAR_PAGE+1 its bottom half.
- PIXEL_LATENCY, 2, cycles the address is held before the generator byte is captured. Minimum 1.
- AUTO_REFRESH, 0, when 1 a new frame starts immediately after o_frameDone without i_start.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  synchronous active-low reset
- i_start  input  1  request one frame refresh; sampled only in IDLE
- i_value  input  8  live progress value, 0..255
- o_value  output  8  frame-latched value to the progressbar generator
- o_pixelAddress  output  10  {page[2:0], column[6:0]} to both generators
- i_textData  input  8  byte from the text-row generator
- i_barData  input  8  byte from the progressbar-row generator
- o_byte  output  8  byte to the SPI sender
- o_byteValid  output  1  o_byte is valid
- i_byteReady  input  1  SPI sender accepts o_byte this cycle
- o_busy  output  1  frame in progress
- o_frameDone  output  1  one-cycle pulse after byte 1023 is accepted

Behaviour:
- Reset (i_rst_n low at a clock edge):
  - State goes to IDLE.
  - All outputs reset to 0: o_value, o_pixelAddress, o_byte, o_byteValid, o_busy, o_frameDone.
  - The hold counter clears.
  - Reset mid-frame abandons the frame with no o_frameDone pulse. The next frame restarts at address 0.
- States: IDLE, HOLD, SEND, DONE.
- IDLE:
  - o_busy=0.
  - On i_start=1, or AUTO_REFRESH=1 with DONE just left: o_value<=i_value, o_pixelAddress<=0, hold counter<=0, o_busy<=1, go to HOLD.
  - o_value changes only on this transition.
- HOLD:
  - o_pixelAddress is held stable and the counter increments each cycle.
  - When the counter reaches PIXEL_LATENCY-1, capture the byte and go to SEND.
  - Byte captured: o_byte<=i_barData if page==BAR_PAGE or page==BAR_PAGE+1, else i_textData. page is o_pixelAddress[9:7].
  - Same edge: o_byteValid<=1.
  - Address-to-capture latency is exactly PIXEL_LATENCY cycles after the address is first presented.
- SEND:
  - o_byte and o_byteValid are held stable until i_byteReady=1 while o_byteValid=1. i_byteReady while o_byteValid=0 is ignored.
  - On acceptance: o_byteValid<=0.
  - If address==1023, go to DONE. Otherwise address<=address+1, counter<=0, go to HOLD.
  - Column 127 wraps to column 0 of the next page through plain 10-bit increment; there is no special page handling.
- DONE:
  - o_frameDone=1 for exactly one cycle, o_busy<=0.
  - Go to IDLE. With AUTO_REFRESH=1, go directly into a new frame start: value relatched, address 0.
- i_start while o_busy=1 is ignored, not queued. i_start held high in IDLE starts exactly one frame per IDLE visit.
- Throughput with i_byteReady tied high: one byte per PIXEL_LATENCY+1 cycles. A frame then takes 1024*(PIXEL_LATENCY+1)+2 cycles from i_start to o_frameDone.

Decomposition:
- Shared package lcd_pkg holds:
  - LCD_WIDTH=128, LCD_PAGES=8, ADDR_W=10, FRAME_BYTES=1024.
  - The state encoding constants IDLE/HOLD/SEND/DONE.
- No sub-module. The block is a single FSM with an address counter and a hold counter.
- The top level instantiates this block alongside the generators and the SPI sender.

Test Plan:
- Reset, then i_start pulse with i_value=100, i_byteReady=1, PIXEL_LATENCY=2: 1024 bytes in address order; o_value=100 throughout; o_frameDone one pulse at cycle 3074 after i_start; o_busy then 0.
- Generator select: text model returns 8'hAA, bar model returns 8'h55: bytes 256..511 (pages 2,3) are 8'h55, all others 8'hAA.
- Backpressure: hold i_byteReady=0 for 5 cycles at address 130: o_byte and o_byteValid stable, o_pixelAddress stays 130; resumes at 131 after acceptance.
- Value change mid-frame: i_value 40->200 at address 500: o_value stays 40 until the next frame start.
- Reset mid-frame: assert i_rst_n=0 at address 700: all outputs 0 next cycle, no o_frameDone; a subsequent i_start begins at address 0.
- i_start pulsed during busy: ignored. With AUTO_REFRESH=1: a second frame begins the cycle after o_frameDone, address 0, o_value relatched.
